mips32_fetch_queue: RTL

//  Instruction-fetch front end for the mips32 pipeline; sits directly upstream of the ID stage and replaces the single-register IF stage.

---
 rtl/mips32_pkg.sv | 35 +++
 rtl/mips32_fetch_queue_if.sv | 34 +++
 rtl/mips32_sync_fifo.sv | 60 ++++++
 rtl/mips32_fetch_queue.sv | 97 +++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 pipeline: opcodes, instruction type codes
// and the default instruction word-address width.
package mips32_pkg;

    localparam int DEFAULT_ADDR_W = 10;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd8;
    localparam logic [5:0] OP_SW    = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd10;
    localparam logic [5:0] OP_SUBI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_BNEQZ = 6'd13;
    localparam logic [5:0] OP_BEQZ  = 6'd14;
    localparam logic [5:0] OP_HLT   = 6'd63;

    typedef enum logic [2:0] {
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT
    } instr_type_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] ir);
        return ir[31:26];
    endfunction

endpackage

// File: rtl/mips32_fetch_queue_if.sv
// Handshake bundle of the fetch queue: instruction-memory read port, the
// valid/ready link to ID, and the branch redirect from EX/MEM.
interface mips32_fetch_queue_if #(
    parameter int ADDR_W = mips32_pkg::DEFAULT_ADDR_W
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic [31:0]       if_ir;
    logic [31:0]       if_npc;
    logic              if_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fetch_halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output if_valid, if_ir, if_npc,
        input  if_ready, redirect, redirect_pc,
        output fetch_halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  if_valid, if_ir, if_npc,
        output if_ready, redirect, redirect_pc,
        input  fetch_halted
    );
endinterface

// File: rtl/mips32_sync_fifo.sv
// Synchronous FIFO with push/pop/flush; a push is accepted on a full FIFO
// only when a pop happens in the same cycle.
module mips32_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];
    assign w_push  = i_push & (~o_full | i_pop);
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// Instruction-fetch front end: credit-limited requests to a variable-latency
// instruction memory, a FIFO of {IR, fetch address} toward ID, redirect and halt.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      HLT_OP   = OP_HLT
) (
    input logic clk,
    input logic rst,
    mips32_fetch_queue_if.master fq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_drop;
    logic              r_halted;

    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_pending;
    logic [CW:0]       w_inflight;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_is_hlt;
    logic [ADDR_W-1:0] w_resp_addr;
    logic [ADDR_W-1:0] w_head_addr;
    logic [31:0]       w_head_ir;
    logic              w_data_full;
    logic              w_shadow_full;
    logic              w_shadow_empty;
    logic              w_unused_flags;

    assign w_inflight = {1'b0, w_count} + {1'b0, w_pending};
    assign w_issue    = fq.imem_req & fq.imem_gnt;
    assign w_push     = fq.imem_rvalid & (r_drop == '0) & ~fq.redirect;
    assign w_pop      = fq.if_valid & fq.if_ready & ~fq.redirect;
    assign w_is_hlt   = w_push & (opcode_of(fq.imem_rdata) == HLT_OP);

    // Credit rule: never have more words outstanding than free FIFO slots.
    assign fq.imem_req     = ~rst & ~r_halted & ~fq.redirect & (w_inflight < (CW+1)'(DEPTH));
    assign fq.imem_addr    = r_pc;
    assign fq.if_valid     = ~w_empty;
    assign fq.if_ir        = w_head_ir;
    assign fq.if_npc       = {{(32-ADDR_W){1'b0}}, w_head_addr + ADDR_W'(1)};
    assign fq.fetch_halted = r_halted;

    assign w_unused_flags = &{w_data_full, w_shadow_full, w_shadow_empty};

    // Issue-address shadow: its occupancy is the in-flight (pending) count,
    // and it is never flushed so that dropped responses still retire in order.
    mips32_sync_fifo #(.DEPTH(DEPTH), .WIDTH(ADDR_W)) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_issue),
        .i_pop   (fq.imem_rvalid),
        .i_flush (1'b0),
        .i_wdata (r_pc),
        .o_rdata (w_resp_addr),
        .o_count (w_pending),
        .o_full  (w_shadow_full),
        .o_empty (w_shadow_empty)
    );

    mips32_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32 + ADDR_W)) u_data (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (fq.redirect),
        .i_wdata ({fq.imem_rdata, w_resp_addr}),
        .o_rdata ({w_head_ir, w_head_addr}),
        .o_count (w_count),
        .o_full  (w_data_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_drop   <= '0;
            r_halted <= 1'b0;
        end else if (fq.redirect) begin
            r_pc     <= fq.redirect_pc;
            r_halted <= 1'b0;
            r_drop   <= w_pending - {{(CW-1){1'b0}}, fq.imem_rvalid};
        end else begin
            if (w_issue)                          r_pc     <= r_pc + ADDR_W'(1);
            if (fq.imem_rvalid && r_drop != '0)   r_drop   <= r_drop - CW'(1);
            if (w_is_hlt)                         r_halted <= 1'b1;
        end
    end

endmodule
